// File: rtl/ysyx_23060025_axi_sram_slave_if.sv
// AXI-lite read/write channel bundle between the core-side master and the SRAM slave.
// Ports: AR (addr/valid/size/ready), R (data/resp/valid/ready), AW, W (data/strb), B (resp/valid/ready).
interface ysyx_23060025_axi_sram_slave_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic [ADDR_LEN-1:0] addr_r_addr_i;
    logic                addr_r_valid_i;
    logic [2:0]          addr_r_size_i;
    logic                addr_r_ready_o;
    logic [DATA_LEN-1:0] r_data_o;
    logic [1:0]          r_resp_o;
    logic                r_valid_o;
    logic                r_ready_i;
    logic [ADDR_LEN-1:0] addr_w_addr_i;
    logic                addr_w_valid_i;
    logic [2:0]          addr_w_size_i;
    logic                addr_w_ready_o;
    logic [DATA_LEN-1:0] w_data_i;
    logic [3:0]          w_strb_i;
    logic                w_valid_i;
    logic                w_ready_o;
    logic [1:0]          bkwd_resp_o;
    logic                bkwd_valid_o;
    logic                bkwd_ready_i;

    modport slave (
        input  addr_r_addr_i, addr_r_valid_i, addr_r_size_i,
        output addr_r_ready_o,
        output r_data_o, r_resp_o, r_valid_o,
        input  r_ready_i,
        input  addr_w_addr_i, addr_w_valid_i, addr_w_size_i,
        output addr_w_ready_o,
        input  w_data_i, w_strb_i, w_valid_i,
        output w_ready_o,
        output bkwd_resp_o, bkwd_valid_o,
        input  bkwd_ready_i
    );

    modport master (
        output addr_r_addr_i, addr_r_valid_i, addr_r_size_i,
        input  addr_r_ready_o,
        input  r_data_o, r_resp_o, r_valid_o,
        output r_ready_i,
        output addr_w_addr_i, addr_w_valid_i, addr_w_size_i,
        input  addr_w_ready_o,
        output w_data_i, w_strb_i, w_valid_i,
        input  w_ready_o,
        input  bkwd_resp_o, bkwd_valid_o,
        output bkwd_ready_i
    );
endinterface

// File: rtl/ysyx_23060025_axi_sram_slave.sv
// AXI-lite slave backed by a word-wide SRAM; single outstanding request, read wins ties.
// Ports: clock, rstn (sync, active-low), bus (slave modport). Macro SRAM_DELAY_EN adds LFSR wait states.
module ysyx_23060025_axi_sram_slave #(
    parameter int                   DATA_LEN  = 32,
    parameter int                   ADDR_LEN  = 32,
    parameter int                   DEPTH     = 1024,
    parameter logic [ADDR_LEN-1:0]  BASE_ADDR = 32'h8000_0000
) (
    input  logic clock,
    input  logic rstn,
    ysyx_23060025_axi_sram_slave_if.slave bus
);
    localparam int                  IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_LEN-1:0] LIMIT  = ADDR_LEN'(DEPTH * 4);
    localparam logic [1:0]          OKAY   = 2'b00;
    localparam logic [1:0]          SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, R_RESP, B_RESP, WAIT} state_e;

    state_e              state_q;
    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic [DATA_LEN-1:0] r_data_q;
    logic [1:0]          r_resp_q;
    logic                r_valid_q;
    logic [1:0]          b_resp_q;
    logic                b_valid_q;

    logic                idle;
    logic                r_fire;
    logic                w_fire;
    logic [ADDR_LEN-1:0] r_off;
    logic [ADDR_LEN-1:0] w_off;
    logic                r_hit;
    logic                w_hit;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx;
    logic                unused_ok;

    // Gating with rstn keeps every ready low while reset is held,
    // so nothing can handshake (or write the array) in a reset cycle.
    assign idle   = rstn && (state_q == IDLE);
    assign r_fire = idle && bus.addr_r_valid_i;
    // Write readies only rise once both valids are present; a pending
    // read takes the slot instead.
    assign w_fire = idle && bus.addr_w_valid_i && bus.w_valid_i
                    && !bus.addr_r_valid_i;

    assign r_off = bus.addr_r_addr_i - BASE_ADDR;
    assign w_off = bus.addr_w_addr_i - BASE_ADDR;
    assign r_hit = r_off < LIMIT;
    assign w_hit = w_off < LIMIT;
    assign r_idx = r_off[IDX_W+1:2];
    assign w_idx = w_off[IDX_W+1:2];

    assign bus.addr_r_ready_o = idle;
    assign bus.addr_w_ready_o = w_fire;
    assign bus.w_ready_o      = w_fire;
    assign bus.r_data_o       = r_data_q;
    assign bus.r_resp_o       = r_resp_q;
    assign bus.r_valid_o      = r_valid_q;
    assign bus.bkwd_resp_o    = b_resp_q;
    assign bus.bkwd_valid_o   = b_valid_q;

    assign unused_ok = ^{bus.addr_r_size_i, bus.addr_w_size_i};

    always_ff @(posedge clock) begin
        if (w_fire && w_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.w_strb_i[k]) begin
                    mem_q[w_idx][8*k +: 8] <= bus.w_data_i[8*k +: 8];
                end
            end
        end
    end

`ifdef SRAM_DELAY_EN
    logic [3:0] lfsr_q;
    logic [3:0] cnt_q;
    logic       rd_q;

    // x^4 + x^3 + 1, free-running from a non-zero seed
    always_ff @(posedge clock) begin
        if (!rstn) begin
            lfsr_q <= 4'b0001;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q   <= IDLE;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
            r_valid_q <= 1'b0;
            b_resp_q  <= OKAY;
            b_valid_q <= 1'b0;
`ifdef SRAM_DELAY_EN
            cnt_q     <= 4'd0;
            rd_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (r_fire) begin
                        r_data_q <= r_hit ? mem_q[r_idx] : '0;
                        r_resp_q <= r_hit ? OKAY : SLVERR;
`ifdef SRAM_DELAY_EN
                        rd_q <= 1'b1;
                        if (lfsr_q != 4'd0) begin
                            cnt_q   <= lfsr_q - 4'd1;
                            state_q <= WAIT;
                        end else begin
                            r_valid_q <= 1'b1;
                            state_q   <= R_RESP;
                        end
`else
                        r_valid_q <= 1'b1;
                        state_q   <= R_RESP;
`endif
                    end else if (w_fire) begin
                        b_resp_q <= w_hit ? OKAY : SLVERR;
`ifdef SRAM_DELAY_EN
                        rd_q <= 1'b0;
                        if (lfsr_q != 4'd0) begin
                            cnt_q   <= lfsr_q - 4'd1;
                            state_q <= WAIT;
                        end else begin
                            b_valid_q <= 1'b1;
                            state_q   <= B_RESP;
                        end
`else
                        b_valid_q <= 1'b1;
                        state_q   <= B_RESP;
`endif
                    end
                end
                R_RESP: begin
                    if (bus.r_ready_i) begin
                        r_valid_q <= 1'b0;
                        r_data_q  <= '0;
                        r_resp_q  <= OKAY;
                        state_q   <= IDLE;
                    end
                end
                B_RESP: begin
                    if (bus.bkwd_ready_i) begin
                        b_valid_q <= 1'b0;
                        b_resp_q  <= OKAY;
                        state_q   <= IDLE;
                    end
                end
                WAIT: begin
`ifdef SRAM_DELAY_EN
                    if (cnt_q == 4'd0) begin
                        if (rd_q) begin
                            r_valid_q <= 1'b1;
                            state_q   <= R_RESP;
                        end else begin
                            b_valid_q <= 1'b1;
                            state_q   <= B_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
`else
                    state_q <= IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_axi_sram_slave.sv
// Directed bench for the AXI-lite SRAM slave.
// Drives the master side of the bus interface and checks responses.
module tb_ysyx_23060025_axi_sram_slave;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    ysyx_23060025_axi_sram_slave_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    ysyx_23060025_axi_sram_slave #(
        .DATA_LEN (32),
        .ADDR_LEN (32),
        .DEPTH    (1024),
        .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clock(clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.addr_r_addr_i  = '0;
        bus.addr_r_valid_i = 1'b0;
        bus.addr_r_size_i  = 3'd2;
        bus.r_ready_i      = 1'b0;
        bus.addr_w_addr_i  = '0;
        bus.addr_w_valid_i = 1'b0;
        bus.addr_w_size_i  = 3'd2;
        bus.w_data_i       = '0;
        bus.w_strb_i       = '0;
        bus.w_valid_i      = 1'b0;
        bus.bkwd_ready_i   = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp,
                            output int lat);
        int n;
        bus.addr_w_addr_i  = a;
        bus.w_data_i       = d;
        bus.w_strb_i       = s;
        bus.addr_w_valid_i = 1'b1;
        bus.w_valid_i      = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.w_ready_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.addr_w_valid_i = 1'b0;
        bus.w_valid_i      = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.bkwd_valid_o && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 20 || n >= 20) lat = -1;
        resp = bus.bkwd_resp_o;
        bus.bkwd_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.bkwd_ready_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n;
        bus.addr_r_addr_i  = a;
        bus.addr_r_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.addr_r_ready_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.addr_r_valid_i = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.r_valid_o && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 20 || n >= 20) lat = -1;
        d    = bus.r_data_o;
        resp = bus.r_resp_o;
        bus.r_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] got;
        rstn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {bus.r_data_o, bus.r_resp_o, bus.bkwd_resp_o,
               bus.r_valid_o, bus.bkwd_valid_o};
        total++;
        if (got !== 38'd0) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=0", got);
        end
        total++;
        if ({bus.addr_r_ready_o, bus.addr_w_ready_o, bus.w_ready_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_readies got=%b exp=000",
                     {bus.addr_r_ready_o, bus.addr_w_ready_o, bus.w_ready_o});
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.addr_r_ready_o, bus.addr_w_ready_o, bus.w_ready_o} !== 3'b100) begin
            bad++;
            $display("FAIL idle_readies got=%b exp=100",
                     {bus.addr_r_ready_o, bus.addr_w_ready_o, bus.w_ready_o});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, r, lat);
        total++;
        if (r !== 2'b00 || lat !== 0) begin
            bad++;
            $display("FAIL wr_full got resp=%b lat=%0d exp resp=00 lat=0", r, lat);
        end
        do_read(32'h8000_0010, d, r, lat);
        total++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat !== 0) begin
            bad++;
            $display("FAIL rd_full got %h/%b/%0d exp deadbeef/00/0", d, r, lat);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0010, 32'h0000_AB00, 4'b0010, r, lat);
        do_read(32'h8000_0010, d, r, lat);
        total++;
        if (d !== 32'hDEAD_ABEF || r !== 2'b00) begin
            bad++;
            $display("FAIL strb_lane1 got %h/%b exp deadabef/00", d, r);
        end
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, r, lat);
        total++;
        if (r !== 2'b00) begin
            bad++;
            $display("FAIL strb_zero_resp got %b exp 00", r);
        end
        do_read(32'h8000_0010, d, r, lat);
        total++;
        if (d !== 32'hDEAD_ABEF) begin
            bad++;
            $display("FAIL strb_zero_data got %h exp deadabef", d);
        end
        do_write(32'h8000_0014, 32'h1122_3344, 4'b1001, r, lat);
        do_write(32'h8000_0014, 32'hAABB_CCDD, 4'b0110, r, lat);
        do_read(32'h8000_0014, d, r, lat);
        total++;
        if (d !== 32'h11BB_CC44) begin
            bad++;
            $display("FAIL strb_merge got %h exp 11bbcc44", d);
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_read(32'h8000_0012, d, r, lat);
        total++;
        if (d !== 32'hDEAD_ABEF || r !== 2'b00) begin
            bad++;
            $display("FAIL rd_unaligned got %h/%b exp deadabef/00", d, r);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0000, 32'h1111_1111, 4'b1111, r, lat);
        do_write(32'h8000_0FFC, 32'h7777_8888, 4'b1111, r, lat);
        total++;
        if (r !== 2'b00) begin
            bad++;
            $display("FAIL wr_last_word got %b exp 00", r);
        end
        do_read(32'h8000_0FFC, d, r, lat);
        total++;
        if (d !== 32'h7777_8888 || r !== 2'b00) begin
            bad++;
            $display("FAIL rd_last_word got %h/%b exp 77778888/00", d, r);
        end
        do_read(32'h8000_1000, d, r, lat);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL rd_oor got %h/%b exp 00000000/10", d, r);
        end
        do_write(32'h8000_1000, 32'h1234_5678, 4'b1111, r, lat);
        total++;
        if (r !== 2'b10 || lat !== 0) begin
            bad++;
            $display("FAIL wr_oor got %b/%0d exp 10/0", r, lat);
        end
        do_read(32'h8000_0000, d, r, lat);
        total++;
        if (d !== 32'h1111_1111) begin
            bad++;
            $display("FAIL oor_no_alias got %h exp 11111111", d);
        end
        do_read(32'h7FFF_FFFC, d, r, lat);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL rd_below_base got %h/%b exp 00000000/10", d, r);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bus.addr_r_addr_i  = 32'h8000_0010;
        bus.addr_r_valid_i = 1'b1;
        bus.addr_w_addr_i  = 32'h8000_0020;
        bus.w_data_i       = 32'hCAFE_F00D;
        bus.w_strb_i       = 4'b1111;
        bus.addr_w_valid_i = 1'b1;
        bus.w_valid_i      = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.addr_r_ready_o, bus.addr_w_ready_o, bus.w_ready_o} !== 3'b100) begin
            bad++;
            $display("FAIL prio_readies got=%b exp=100",
                     {bus.addr_r_ready_o, bus.addr_w_ready_o, bus.w_ready_o});
        end
        @(posedge clk);
        #1;
        bus.addr_r_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.r_valid_o, bus.addr_w_ready_o, bus.w_ready_o} !== 3'b100
            || bus.r_data_o !== 32'hDEAD_ABEF) begin
            bad++;
            $display("FAIL prio_rresp got v/awr/wr=%b data=%h exp 100 deadabef",
                     {bus.r_valid_o, bus.addr_w_ready_o, bus.w_ready_o},
                     bus.r_data_o);
        end
        bus.r_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.addr_w_ready_o, bus.w_ready_o, bus.r_valid_o} !== 3'b110) begin
            bad++;
            $display("FAIL prio_wr_next got awr/wr/rv=%b exp 110",
                     {bus.addr_w_ready_o, bus.w_ready_o, bus.r_valid_o});
        end
        @(posedge clk);
        #1;
        bus.addr_w_valid_i = 1'b0;
        bus.w_valid_i      = 1'b0;
        @(negedge clk);
        total++;
        if (bus.bkwd_valid_o !== 1'b1 || bus.bkwd_resp_o !== 2'b00) begin
            bad++;
            $display("FAIL prio_bresp got v=%b resp=%b exp 1/00",
                     bus.bkwd_valid_o, bus.bkwd_resp_o);
        end
        bus.bkwd_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.bkwd_ready_i = 1'b0;
        do_read(32'h8000_0020, d, r, lat);
        total++;
        if (d !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL prio_wr_data got %h exp cafef00d", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        bus.addr_r_addr_i  = 32'h8000_0010;
        bus.addr_r_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.addr_r_valid_i = 1'b0;
        @(negedge clk);
        first = bus.r_data_o;
        total++;
        if (first !== 32'hDEAD_ABEF) begin
            bad++;
            $display("FAIL bp_first got %h exp deadabef", first);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== 32'hDEAD_ABEF
                || bus.r_resp_o !== 2'b00 || bus.addr_r_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp 1 deadabef 0",
                         i, bus.r_valid_o, bus.r_data_o, bus.addr_r_ready_o);
            end
        end
        bus.r_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready_i = 1'b0;
        @(negedge clk);
        total++;
        if (bus.r_valid_o !== 1'b0 || bus.r_data_o !== 32'h0
            || bus.r_resp_o !== 2'b00 || bus.addr_r_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_done got v=%b d=%h rdy=%b exp 0 0 1",
                     bus.r_valid_o, bus.r_data_o, bus.addr_r_ready_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0030, 32'h0000_0000, 4'b1111, r, lat);
        bus.addr_r_addr_i  = 32'h8000_0010;
        bus.addr_r_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.addr_r_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        bus.addr_w_addr_i  = 32'h8000_0030;
        bus.w_data_i       = 32'hFFFF_FFFF;
        bus.w_strb_i       = 4'b1111;
        bus.addr_w_valid_i = 1'b1;
        bus.w_valid_i      = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.r_valid_o, bus.r_data_o, bus.r_resp_o, bus.addr_r_ready_o,
             bus.addr_w_ready_o, bus.w_ready_o, bus.bkwd_valid_o} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outs got v=%b d=%h rdy=%b%b%b exp all 0",
                     bus.r_valid_o, bus.r_data_o, bus.addr_r_ready_o,
                     bus.addr_w_ready_o, bus.w_ready_o);
        end
        @(posedge clk);
        #1;
        bus.addr_w_valid_i = 1'b0;
        bus.w_valid_i      = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (bus.addr_r_ready_o !== 1'b1 || bus.r_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle got rdy=%b v=%b exp 1 0",
                     bus.addr_r_ready_o, bus.r_valid_o);
        end
        do_read(32'h8000_0030, d, r, lat);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL rst_no_write got %h exp 00000000", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h8000_0040, 32'h0102_0304, 4'b1111, r, lat);
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL b2b_w1 got lat=%0d exp 0", lat);
        end
        do_write(32'h8000_0040, 32'hA0B0_C0D0, 4'b1100, r, lat);
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL b2b_w2 got lat=%0d exp 0", lat);
        end
        do_read(32'h8000_0040, d, r, lat);
        total++;
        if (d !== 32'hA0B0_0304 || lat !== 0) begin
            bad++;
            $display("FAIL b2b_raw got %h/%0d exp a0b00304/0", d, lat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_strobe();
        test_unaligned();
        test_range();
        test_priority();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
